// File: rtl/key_event_ctrl.sv
// Debounces active-low push buttons into clean levels, press/release strobes and
// sticky per-key events with write-1-to-clear acknowledge and a single irq line.
module key_event_ctrl #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                MAX10_CLK1_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] event_pending,
  output logic [NUM_KEYS-1:0] overrun,
  input  logic [NUM_KEYS-1:0] ack,
  output logic                irq
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync_p;

  // Reset value 0 means "released" after the inversion of the active-low pins
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      sync_meta <= '0;
      sync_p    <= '0;
    end else begin
      sync_meta <= ~KEY;
      sync_p    <= sync_meta;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_q, level_next;
    logic             press_q, press_next;
    logic             release_q, release_next;

    always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_next;
        cnt       <= cnt_next;
        level_q   <= level_next;
        press_q   <= press_next;
        release_q <= release_next;
      end
    end

    // The counter stops at CNT_MAX because reaching it always leaves the wait state
    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      level_next   = level_q;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state)
        IDLE: begin
          if (sync_p[g]) begin
            state_next = PRESS_WAIT;
            cnt_next   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_p[g]) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == CNT_MAX) begin
            state_next = HELD;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync_p[g]) begin
            state_next = RELEASE_WAIT;
            cnt_next   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync_p[g]) begin
            state_next = HELD;
            cnt_next   = '0;
          end else if (cnt == CNT_MAX) begin
            state_next   = IDLE;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    assign key_level[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
  end

  // A press arriving with its ack keeps the new event and discards the overrun
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      event_pending <= '0;
      overrun       <= '0;
      irq           <= 1'b0;
    end else begin
      event_pending <= (event_pending & ~ack) | press_pulse;
      overrun       <= (overrun | (press_pulse & event_pending)) & ~ack;
      irq           <= |event_pending;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: expected pulses are queued by the stimulus
// thread and matched by a monitor whenever the DUT emits a press or release strobe.
module tb_key_event_ctrl;

  localparam int NK = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] KEY;
  logic [NK-1:0] ack;
  logic [NK-1:0] key_level, press_pulse, release_pulse, event_pending, overrun;
  logic          irq;

  int edge_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  typedef struct {
    int          edge_n;
    logic [NK-1:0] p;
    logic [NK-1:0] r;
  } exp_t;
  exp_t exp_q[$];

  key_event_ctrl #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .KEY(KEY),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .event_pending(event_pending),
    .overrun(overrun),
    .ack(ack),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, req, edge_cnt);
    end
  endtask

  // Pulse visible at negedge following edge: drive edge + 2 sync + DB debounce + 1
  task automatic push_exp(input logic [NK-1:0] p, input logic [NK-1:0] r, input int offset);
    exp_t e;
    e.edge_n = edge_cnt + offset;
    e.p = p;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack(input logic [NK-1:0] a);
    ack = a;
    wait_cycles(1);
    ack = '0;
  endtask

  // Monitor: every strobe must match the head of the queue, including its edge
  always @(negedge clk) begin
    if (!reset && ((press_pulse | release_pulse) != '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: press=%b release=%b at edge %0d, none expected",
                 press_pulse, release_pulse, edge_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_edge", 8'(edge_cnt), 8'(e.edge_n));
        check("press_pulse", 8'(press_pulse), 8'(e.p));
        check("release_pulse", 8'(release_pulse), 8'(e.r));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    KEY   = 2'b00;
    ack   = '0;
    wait_cycles(3);
    // Reset state with both keys held low
    check("rst_level", 8'(key_level), 8'h0);
    check("rst_press", 8'(press_pulse), 8'h0);
    check("rst_release", 8'(release_pulse), 8'h0);
    check("rst_pending", 8'(event_pending), 8'h0);
    check("rst_overrun", 8'(overrun), 8'h0);
    check("rst_irq", 8'(irq), 8'h0);
    reset = 1'b0;
    push_exp(2'b11, 2'b00, 7);
    wait_cycles(10);
    check("both_level", 8'(key_level), 8'h3);
    check("both_pending", 8'(event_pending), 8'h3);
    check("both_irq", 8'(irq), 8'h1);
    pulse_ack(2'b11);
    check("ack_pending", 8'(event_pending), 8'h0);
    check("ack_irq_lag", 8'(irq), 8'h1);
    wait_cycles(1);
    check("ack_irq", 8'(irq), 8'h0);
    KEY = 2'b11;
    push_exp(2'b00, 2'b11, 7);
    wait_cycles(10);
    check("rel_level", 8'(key_level), 8'h0);
    check("rel_no_event", 8'(event_pending), 8'h0);

    // Clean press of key 0 and irq lag
    KEY = 2'b10;
    push_exp(2'b01, 2'b00, 7);
    wait_cycles(8);
    check("clean_pending", 8'(event_pending), 8'h1);
    check("clean_irq_lag", 8'(irq), 8'h0);
    wait_cycles(1);
    check("clean_irq", 8'(irq), 8'h1);
    check("clean_level", 8'(key_level), 8'h1);
    pulse_ack(2'b01);
    KEY = 2'b11;
    push_exp(2'b00, 2'b01, 7);
    wait_cycles(10);

    // Press bounce: never stable for DB cycles
    KEY = 2'b10; wait_cycles(3);
    KEY = 2'b11; wait_cycles(1);
    KEY = 2'b10; wait_cycles(3);
    KEY = 2'b11; wait_cycles(8);
    check("bounce_level", 8'(key_level), 8'h0);
    check("bounce_pending", 8'(event_pending), 8'h0);

    // Release bounce while held
    KEY = 2'b10;
    push_exp(2'b01, 2'b00, 7);
    wait_cycles(10);
    pulse_ack(2'b01);
    KEY = 2'b11; wait_cycles(3);
    KEY = 2'b10; wait_cycles(1);
    KEY = 2'b11; wait_cycles(3);
    KEY = 2'b10; wait_cycles(8);
    check("rbounce_level", 8'(key_level), 8'h1);
    KEY = 2'b11;
    push_exp(2'b00, 2'b01, 7);
    wait_cycles(10);

    // Overrun on key 1
    KEY = 2'b01;
    push_exp(2'b10, 2'b00, 7);
    wait_cycles(10);
    check("ovr_first", 8'(overrun), 8'h0);
    KEY = 2'b11;
    push_exp(2'b00, 2'b10, 7);
    wait_cycles(10);
    KEY = 2'b01;
    push_exp(2'b10, 2'b00, 7);
    wait_cycles(10);
    check("ovr_set", 8'(overrun), 8'h2);
    check("ovr_pending", 8'(event_pending), 8'h2);
    KEY = 2'b11;
    push_exp(2'b00, 2'b10, 7);
    wait_cycles(10);
    pulse_ack(2'b10);
    check("ovr_clr_pending", 8'(event_pending), 8'h0);
    check("ovr_clr_overrun", 8'(overrun), 8'h0);
    wait_cycles(1);
    check("ovr_clr_irq", 8'(irq), 8'h0);

    // Collision: ack arrives with the second press pulse
    KEY = 2'b10;
    push_exp(2'b01, 2'b00, 7);
    wait_cycles(10);
    KEY = 2'b11;
    push_exp(2'b00, 2'b01, 7);
    wait_cycles(10);
    check("col_pre_pending", 8'(event_pending), 8'h1);
    KEY = 2'b10;
    push_exp(2'b01, 2'b00, 7);
    wait_cycles(7);
    pulse_ack(2'b01);
    check("col_pending", 8'(event_pending), 8'h1);
    check("col_overrun", 8'(overrun), 8'h0);
    pulse_ack(2'b01);
    KEY = 2'b11;
    push_exp(2'b00, 2'b01, 7);
    wait_cycles(10);

    // Reset during PRESS_WAIT with cnt at 2, key held through it
    KEY = 2'b10;
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check("midrst_level", 8'(key_level), 8'h0);
    push_exp(2'b01, 2'b00, 7);
    wait_cycles(10);
    check("midrst_after", 8'(key_level), 8'h1);
    KEY = 2'b11;
    push_exp(2'b00, 2'b01, 7);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_cycles(1);
    wait_cycles(2);
    check("queue_drained", 8'(exp_q.size()), 8'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
